dmem_wait: RTL

Multi-cycle data-memory responder for the pipelined MIPS core. It answers the processor's load/store interface (memread, memwrite, sb, dataadr, writedata, readdata) with a programmable number of wait states. It raises `stall` so the pipeline freezes until the access completes. It drops in where the single-cycle data memory sits today and models slow external RAM.

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/dmem_wait_fsm.sv | 94 +++++++++
 rtl/dmem_wait.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory models.
// Used by dmem_wait and dmem_wait_fsm.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    localparam int unsigned DBG_WORDS = 10;

    // Replace one little-endian byte lane of a word
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [7:0]  bval,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = bval;
        return res;
    endfunction

endpackage

// File: rtl/dmem_wait_fsm.sv
// Request sequencer for dmem_wait: latches the access, counts wait states,
// drives stall and pulses do_access on the completing edge.
module dmem_wait_fsm
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW          = 6,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic          sb,
    input  logic [31:0]   dataadr,
    input  logic [31:0]   writedata,
    output logic          stall,
    output logic          do_access,
    output logic [AW+1:0] acc_adr,
    output logic [31:0]   acc_wdata,
    output logic          acc_sb,
    output logic          acc_wr
);

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] adr_q, adr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          sb_q, sb_d;
    logic          wr_q, wr_d;
    logic          req;

    // Upper address bits alias onto the array and are deliberately dropped
    logic [31-(AW+2):0] unused_adr;
    assign unused_adr = dataadr[31:AW+2];

    assign req = memread | memwrite;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        sb_d      = sb_q;
        wr_d      = wr_q;
        do_access = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = 4'(WAIT_STATES);
                    adr_d   = dataadr[AW+1:0];
                    wdata_d = writedata;
                    sb_d    = sb;
                    wr_d    = memwrite;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = DONE;
                    do_access = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            wdata_q <= 32'd0;
            sb_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            sb_q    <= sb_d;
            wr_q    <= wr_d;
        end
    end

    assign stall     = reset & (((state_q == IDLE) & req) | (state_q == BUSY));
    assign acc_adr   = adr_q;
    assign acc_wdata = wdata_q;
    assign acc_sb    = sb_q;
    assign acc_wr    = wr_q;

endmodule

// File: rtl/dmem_wait.sv
// Multi-cycle data memory with programmable wait states for the pipelined MIPS core.
// Optional alignment checking and the memerr port are enabled by DMEM_ALIGN_CHK_EN.
module dmem_wait
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        sb,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic [31:0] DataMem [DBG_WORDS]
`ifdef DMEM_ALIGN_CHK_EN
    ,
    output logic        memerr
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          do_access;
    logic [AW+1:0] acc_adr;
    logic [31:0]   acc_wdata;
    logic          acc_sb;
    logic          acc_wr;
    logic [AW-1:0] idx;
    logic [31:0]   wr_word;
    logic          misalign;
    logic          wr_en;

    dmem_wait_fsm #(
        .AW          (AW),
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .sb        (sb),
        .dataadr   (dataadr),
        .writedata (writedata),
        .stall     (stall),
        .do_access (do_access),
        .acc_adr   (acc_adr),
        .acc_wdata (acc_wdata),
        .acc_sb    (acc_sb),
        .acc_wr    (acc_wr)
    );

    assign idx     = acc_adr[AW+1:2];
    assign wr_word = acc_sb ? merge_byte(mem[idx], acc_wdata[7:0], acc_adr[1:0]) : acc_wdata;

`ifdef DMEM_ALIGN_CHK_EN
    // Byte stores may hit any lane; only word accesses must be aligned
    assign misalign = (acc_adr[1:0] != 2'b00) && !(acc_wr && acc_sb);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memerr <= 1'b0;
        end else begin
            memerr <= do_access && misalign;
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign wr_en = do_access && acc_wr && !misalign;

    // Array contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= 32'd0;
        end else if (do_access && !acc_wr) begin
            readdata <= mem[idx];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DBG_WORDS); i++) begin
            DataMem[i] = mem[i];
        end
    end

endmodule
